// File: rtl/srp_buff_reader.sv
// Streams one frame of bytes out of a circular BRAM buffer through a 2-entry FIFO.
// Optional feature: define SRP_RD_ABORT_EN to add an abort input that cancels the frame.
module srp_buff_reader #(
  parameter int DEPTH = 2240,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SRP_RD_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  input  logic [DW-1:0] bram_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  state_t        state, state_next;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_left;
  logic [AW-1:0] out_left;
  logic          inflight;
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  logic          abort_hit;
  logic          push, pop, issue;
  logic [2:0]    held;
  logic [AW-1:0] eff_len, start_base;

`ifdef SRP_RD_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign eff_len    = (length > DEPTH_A) ? DEPTH_A : length;
  assign start_base = (start_addr >= DEPTH_A) ? (start_addr - DEPTH_A) : start_addr;

  // Occupancy counts this cycle's pop, so a read can be issued every clock while the sink keeps up.
  assign push  = inflight;
  assign pop   = m_valid && m_ready;
  assign held  = {2'b00, inflight} + {1'b0, count} - {2'b00, pop};
  assign issue = (state == READ) && (held < 3'd2);

  assign bram_en   = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = rd_addr;
  assign m_valid   = (count != 2'd0);
  assign m_data    = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign done      = (state == FIN) && !abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (eff_len == '0) ? FIN : READ;
      READ:  if (issue && rd_left == AW'(1)) state_next = DRAIN;
      DRAIN: if (pop && out_left == AW'(1)) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      rd_left  <= '0;
      out_left <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      // NOTE: the FIFO storage is reset too because its head drives m_data, which must read 0 in reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (abort_hit) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      rd_left  <= '0;
      out_left <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_addr  <= start_base;
        rd_left  <= eff_len;
        out_left <= eff_len;
      end
      inflight <= issue;
      if (issue) begin
        rd_addr <= (rd_addr == LAST_A) ? '0 : rd_addr + AW'(1);
        rd_left <= rd_left - AW'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        out_left <= out_left - AW'(1);
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_srp_buff_reader.sv
// Self-checking bench for srp_buff_reader: directed frames plus randomized frames against a queue model.
module tb_srp_buff_reader;

  localparam int DEPTH = 2240;
  localparam int AW    = 12;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] length;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy, done;
`ifdef SRP_RD_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [DEPTH];

  srp_buff_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SRP_RD_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM model: data one clock after enable.
  always @(posedge clk) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_valid"},   32'(m_valid),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_bram_en"},   32'(bram_en),   32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_m_data"},    32'(m_data),    32'd0);
  endtask

  // Watches a span of cycles after a cancelled frame: nothing may come out.
  task automatic watch_quiet(input string tag, input int cycles);
    int dones = 0, valids = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done)    dones++;
      if (m_valid) valids++;
    end
    check({tag, "_no_done"},  32'(dones),  32'd0);
    check({tag, "_no_valid"}, 32'(valids), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int sa, input int len, input int duty);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held_data = '0;
    int base, n, got = 0, first_k = -1, last_k = -1, done_k = -1, dones = 0, budget;
    bit stall = 0, en_seen = 0, v_seen = 0, we_seen = 0;

    base = (sa >= DEPTH) ? sa - DEPTH : sa;
    n    = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    budget = 4 * n + 50;

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    length     = AW'(len);
    m_ready    = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      if (stall) begin
        check({tag, "_stall_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_stall_data"},  32'(m_data),  32'(held_data));
      end
      m_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      if (bram_en) en_seen = 1;
      if (bram_we) we_seen = 1;
      if (m_valid) begin
        v_seen = 1;
        if (first_k < 0) first_k = k;
      end
      if (m_valid && m_ready) begin
        if (got < n) check({tag, "_data"}, 32'(m_data), 32'(exp_q[got]));
        got++;
        last_k = k;
      end
      stall     = m_valid && !m_ready;
      held_data = m_data;
      if (done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    m_ready = 1'b1;

    check({tag, "_byte_count"}, 32'(got),   32'(n));
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_idle_busy"},  32'(busy),  32'd0);
    check({tag, "_we_low"},     32'(we_seen), 32'd0);
    if (n == 0) begin
      check({tag, "_no_bram_en"}, 32'(en_seen), 32'd0);
      check({tag, "_no_valid"},   32'(v_seen),  32'd0);
      check({tag, "_done_delay"}, 32'(done_k),  32'd1);
    end else if (duty >= 100) begin
      check({tag, "_latency"},    32'(first_k - 1),     32'd2);
      check({tag, "_no_bubbles"}, 32'(last_k - first_k), 32'(n - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    m_ready    = 1'b1;
`ifdef SRP_RD_ABORT_EN
    abort      = 1'b0;
`endif
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame("basic",     100,  16,   100);
    run_frame("wrap",      2236, 8,    100);
    run_frame("zero_len",  50,   0,    100);
    run_frame("clamp",     3000, 4000, 100);
    run_frame("stall30",   200,  64,   30);

    // Reset mid-frame discards everything, then a fresh frame must run cleanly.
    @(negedge clk);
    start = 1'b1; start_addr = AW'(10); length = AW'(64);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("midreset", 8);
    run_frame("after_reset", 2200, 100, 100);

`ifdef SRP_RD_ABORT_EN
    @(negedge clk);
    start = 1'b1; start_addr = AW'(300); length = AW'(64);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy",    32'(busy),    32'd0);
    watch_quiet("abort", 8);
    run_frame("after_abort", 5, 20, 100);
`endif

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int r = 0; r < 4; r++)
      run_frame($sformatf("rand%0d", r), int'($urandom_range(4095)), int'($urandom_range(300, 1)), 30);
    run_frame("rand_full", int'($urandom_range(4095)), 120, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
